sound_cmd_tx: RTL and testbench

Main-CPU-side transmitter for the sound command latch. It queues command bytes written by the main CPU in a FIFO. It delivers them one at a time as single-cycle SND strobes into the sound board's latch. It waits for the Z80's latch acknowledge (the port-3 write, which clears latch-ready) before sending the next byte. This stops back-to-back commands from overwriting an unread latch, and sits between the main CPU IO decode and the sound block.

---
 rtl/sound_cmd_tx.sv | 166 ++++++++++++++++
 tb/tb_sound_cmd_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sound_cmd_tx.sv
// Main-CPU sound command transmitter: queues command bytes and delivers them one at a
// time as SND strobes into the sound latch, holding off until the Z80 acknowledges.
`timescale 1ns/1ps
module sound_cmd_tx #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 2000000
) (
  input  logic          CLK_32M,
  input  logic          RESET_N,
  input  logic          CMD_WR,
  input  logic [7:0]    CMD_DIN,
  input  logic          FLUSH,
  input  logic          LATCH_ACK,
  input  logic          STATUS_CLR,
  output logic          SND,
  output logic          SND_A0,
  output logic [7:0]    SND_DATA,
  output logic          BUSY,
  output logic          FIFO_EMPTY,
  output logic          FIFO_FULL,
  output logic [AW:0]   LEVEL,
  output logic          OVERFLOW,
  output logic          TIMEOUT_ERR
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    data_q, data_d;
  logic          snd_q, snd_d;
  logic          ovf_q, ovf_d;
  logic          terr_q, terr_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic fifo_empty, fifo_full;
  logic pop, push, ovf_set, terr_set;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);

  // The head leaves the FIFO on the IDLE->ISSUE transition; a pop frees a slot for a
  // same-cycle write even when full. FLUSH discards a coincident write silently.
  assign pop     = (state_q == ST_IDLE) && !fifo_empty && !FLUSH;
  assign push    = CMD_WR && !FLUSH && (!fifo_full || pop);
  assign ovf_set = CMD_WR && !FLUSH && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (FLUSH) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (push) mem_q[wr_ptr_q] <= CMD_DIN;
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
    terr_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_ISSUE;
          data_d  = mem_q[rd_ptr_q];
        end
      end
      ST_ISSUE: begin
        state_d = LATCH_ACK ? ST_GAP : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Ack beats a timeout landing on the same cycle; a timed-out command is dropped.
        if (LATCH_ACK) begin
          state_d = ST_GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          terr_set = 1'b1;
          state_d  = ST_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
      gap_cnt_d = '0;
    end
  end

  assign snd_d  = (state_d == ST_ISSUE);
  assign ovf_d  = (ovf_q  & ~STATUS_CLR) | ovf_set;
  assign terr_d = (terr_q & ~STATUS_CLR) | terr_set;

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      data_q    <= 8'h00;
      snd_q     <= 1'b0;
      ovf_q     <= 1'b0;
      terr_q    <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      data_q    <= data_d;
      snd_q     <= snd_d;
      ovf_q     <= ovf_d;
      terr_q    <= terr_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign SND         = snd_q;
  assign SND_A0      = 1'b0;
  assign SND_DATA    = data_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign FIFO_EMPTY  = fifo_empty;
  assign FIFO_FULL   = fifo_full;
  assign LEVEL       = level_q;
  assign OVERFLOW    = ovf_q;
  assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_sound_cmd_tx.sv
// Bench for sound_cmd_tx: directed scenarios plus random traffic compared every cycle
// against a timing-level model (command queue, issue/free cycle stamps, sticky flags).
`timescale 1ns/1ps
module tb_sound_cmd_tx;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int G     = 8;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_wr, flush, ack, clr;
  logic [7:0]    cmd_din;
  logic          snd, snd_a0, busy, f_empty, f_full, ovf, terr;
  logic [7:0]    snd_data;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  sound_cmd_tx #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(G), .TIMEOUT(TMO)) dut (
    .CLK_32M(clk), .RESET_N(rst_n), .CMD_WR(cmd_wr), .CMD_DIN(cmd_din),
    .FLUSH(flush), .LATCH_ACK(ack), .STATUS_CLR(clr),
    .SND(snd), .SND_A0(snd_a0), .SND_DATA(snd_data), .BUSY(busy),
    .FIFO_EMPTY(f_empty), .FIFO_FULL(f_full), .LEVEL(level),
    .OVERFLOW(ovf), .TIMEOUT_ERR(terr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: queued bytes, the cycle of the last strobe, whether that byte is still
  // awaiting its ack, and the first cycle at which the block is free to issue again.
  logic [7:0] q[$];
  longint     c;
  longint     issue_c;
  longint     free_c;
  bit         waiting;
  logic [7:0] m_data;
  bit         m_ovf, m_terr;

  task automatic model_reset();
    q.delete();
    issue_c = -1000000;
    free_c  = 0;
    waiting = 0;
    m_data  = 8'h00;
    m_ovf   = 0;
    m_terr  = 0;
  endtask

  task automatic model_step(input bit wr, input logic [7:0] din, input bit fl,
                            input bit ak, input bit cl);
    bit idle, pop, oset, tset;
    idle = !waiting && (c >= free_c);
    pop  = idle && (q.size() > 0) && !fl;
    oset = wr && !fl && (q.size() == DEPTH) && !pop;
    tset = 0;
    if (waiting) begin
      if (ak) begin
        waiting = 0;
        free_c  = c + 1 + G;
      end else if (c == issue_c + TMO) begin
        waiting = 0;
        tset    = 1;
        free_c  = c + 1 + G;
      end
    end
    if (fl) begin
      q.delete();
    end else begin
      if (pop) begin
        m_data  = q.pop_front();
        issue_c = c + 1;
        waiting = 1;
      end
      if (wr && q.size() < DEPTH) q.push_back(din);
    end
    m_ovf  = (m_ovf  && !cl) || oset;
    m_terr = (m_terr && !cl) || tset;
    c++;
  endtask

  task automatic compare_outputs();
    chk("snd",      32'(snd),      32'(c == issue_c));
    chk("snd_a0",   32'(snd_a0),   32'd0);
    chk("snd_data", 32'(snd_data), 32'(m_data));
    chk("busy",     32'(busy),     32'(waiting || (c < free_c)));
    chk("level",    32'(level),    32'(q.size()));
    chk("empty",    32'(f_empty),  32'(q.size() == 0));
    chk("full",     32'(f_full),   32'(q.size() == DEPTH));
    chk("overflow", 32'(ovf),      32'(m_ovf));
    chk("timeout",  32'(terr),     32'(m_terr));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_snd"},   32'(snd),      32'd0);
    chk({tag, "_a0"},    32'(snd_a0),   32'd0);
    chk({tag, "_data"},  32'(snd_data), 32'h00);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_level"}, 32'(level),    32'd0);
    chk({tag, "_empty"}, 32'(f_empty),  32'd1);
    chk({tag, "_full"},  32'(f_full),   32'd0);
    chk({tag, "_ovf"},   32'(ovf),      32'd0);
    chk({tag, "_terr"},  32'(terr),     32'd0);
  endtask

  // One clock cycle: drive inputs just after the edge, check at the falling edge,
  // then advance the model with the inputs the DUT samples on the next edge.
  task automatic cycle(input bit wr, input logic [7:0] din, input bit fl,
                       input bit ak, input bit cl);
    @(posedge clk);
    #1;
    cmd_wr  = wr;
    cmd_din = din;
    flush   = fl;
    ack     = ak;
    clr     = cl;
    @(negedge clk);
    compare_outputs();
    model_step(wr, din, fl, ak, cl);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0);
  endtask

  task automatic reset_during_snd();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cycle(q.size() == 0, 8'($urandom), 0, 1, 0);
      seen = (snd === 1'b1);
    end
    chk("rst_snd_seen", 32'(seen), 32'd1);
    cmd_wr = 0; flush = 0; ack = 0; clr = 0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  int wrp[4] = '{30, 60, 10, 50};
  int akp[4] = '{5,  2,  30, 0};

  initial begin
    rst_n = 1'b0; cmd_wr = 0; cmd_din = 8'h00; flush = 0; ack = 0; clr = 0;
    model_reset();
    c = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single command at cycle 10, ack at cycle 30.
    idle_cycles(10);
    cycle(1, 8'h5A, 0, 0, 0);
    idle_cycles(19);
    cycle(0, 8'h00, 0, 1, 0);
    idle_cycles(G + 4);

    // Back-to-back pushes, acked at intervals.
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h02, 0, 0, 0);
    cycle(1, 8'h03, 0, 0, 0);
    for (int i = 0; i < 60; i++) cycle(0, 8'h00, 0, (i % 15) == 14, 0);

    // Fill to full and overflow with no ack, clear status, let timeouts drain.
    for (int i = 0; i < 12; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0);
    idle_cycles(2);
    cycle(0, 8'h00, 0, 0, 1);
    idle_cycles(1000);
    cycle(0, 8'h00, 0, 0, 1);

    // Ack coincident with the strobe, then an ack while idle.
    cycle(1, 8'hC3, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 0);
    idle_cycles(G + 4);
    cycle(0, 8'h00, 0, 1, 0);
    idle_cycles(2);

    // Flush while waiting on an ack.
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'hA0 + i), 0, 0, 0);
    idle_cycles(3);
    cycle(0, 8'h00, 1, 0, 0);
    idle_cycles(5);
    cycle(0, 8'h00, 0, 1, 0);
    idle_cycles(G + 6);

    // Random traffic with varying write/ack densities.
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 1000; i++) begin
        cycle($urandom_range(0, 99) < wrp[seg], 8'($urandom),
              $urandom_range(0, 99) < 1, $urandom_range(0, 99) < akp[seg],
              $urandom_range(0, 99) < 3);
      end
    end

    reset_during_snd();
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 99) < 40, 8'($urandom), 0, $urandom_range(0, 99) < 10, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
